// File: rtl/axis_uart_tx_arbiter.sv
// axis_uart_tx_arbiter: round-robin packet arbiter merging N AXI-Stream sources into one UART TX FIFO stream
// Ports: clk, rst (asynchronous, active-high)
//   s_data/s_valid/s_last/s_ready : N source streams, source i at s_data[i*WIDTH +: WIDTH]
//   m_data/m_valid/m_last/m_ready : merged downstream stream
//   grant       : one-hot owner of the path, zero when idle
//   busy        : a packet is being passed
//   timeout_err : one-cycle pulse when a stalled source is forcibly released
// Optional feature: define AXIS_UART_ARB_TIMEOUT_EN to release a source that keeps s_valid low
//   for TIMEOUT cycles in the middle of a packet.
module axis_uart_tx_arbiter #(
    parameter int N       = 3,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] s_data,
    input  logic [N-1:0]       s_valid,
    input  logic [N-1:0]       s_last,
    output logic [N-1:0]       s_ready,
    output logic [WIDTH-1:0]   m_data,
    output logic               m_valid,
    output logic               m_last,
    input  logic               m_ready,
    output logic [N-1:0]       grant,
    output logic               busy,
    output logic               timeout_err
);
    localparam int PW = $clog2(N);

    typedef enum logic {IDLE, PASS} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic [PW-1:0] pick;
    logic [PW-1:0] j;
    logic          found;
    logic          pass;
    logic          hs;
    logic          expire;

    // first requester strictly after the last winner, wrapping
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        j     = '0;
        for (int k = 1; k <= N; k++) begin
            j = PW'((int'(ptr) + k) % N);
            if (!found && s_valid[j]) begin
                pick  = j;
                found = 1'b1;
            end
        end
    end

    assign pass    = (state == PASS);
    assign busy    = pass;
    assign m_valid = pass & s_valid[gidx];
    assign m_last  = pass & s_last[gidx];
    assign m_data  = pass ? s_data[32'(gidx)*WIDTH +: WIDTH] : '0;
    assign s_ready = pass ? (N'(m_ready) << gidx) : '0;
    assign hs      = m_valid & m_ready;

`ifdef AXIS_UART_ARB_TIMEOUT_EN
    logic [15:0] cnt;

    // counts PASS cycles with the owner idle; any accepted beat restarts it
    assign expire = pass & ~s_valid[gidx] & (cnt == 16'(TIMEOUT - 1));
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= PW'(N - 1);
            gidx  <= '0;
            grant <= '0;
`ifdef AXIS_UART_ARB_TIMEOUT_EN
            cnt         <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            if (!pass) begin
                if (found) begin
                    state <= PASS;
                    gidx  <= pick;
                    grant <= N'(1) << pick;
                end
            end else if ((hs && m_last) || expire) begin
                state <= IDLE;
                ptr   <= gidx;
                grant <= '0;
            end
`ifdef AXIS_UART_ARB_TIMEOUT_EN
            timeout_err <= expire;
            cnt         <= (!pass || hs || expire) ? '0 : (s_valid[gidx] ? cnt : cnt + 16'd1);
`endif
        end
    end
endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// tb_axis_uart_tx_arbiter: scoreboard bench for axis_uart_tx_arbiter
module tb_axis_uart_tx_arbiter;
    localparam int N  = 3;
    localparam int W  = 8;
    localparam int TO = 8;

    typedef logic [W-1:0] pkt_t[$];

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N*W-1:0] s_data;
    logic [N-1:0]   s_valid;
    logic [N-1:0]   s_last;
    logic [N-1:0]   s_ready;
    logic [W-1:0]   m_data;
    logic           m_valid;
    logic           m_last;
    logic           m_ready = 1'b1;
    logic [N-1:0]   grant;
    logic           busy;
    logic           timeout_err;

    logic         sv [N];
    logic         sl [N];
    logic [W-1:0] sd [N];
    logic         mr_rand  = 1'b0;
    logic         mr_force = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [W:0]   exp_q [N][$];
    logic [N-1:0] glog[$];
    int           to_cnt = 0;
    int           done   = 0;

    axis_uart_tx_arbiter #(.N(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
        .m_ready(m_ready), .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        s_valid = '0;
        s_last  = '0;
        s_data  = '0;
        for (int i = 0; i < N; i++) begin
            s_valid[i]       = sv[i];
            s_last[i]        = sl[i];
            s_data[i*W +: W] = sd[i];
        end
    end

    always @(posedge clk) begin
        #1;
        m_ready = mr_rand ? ($urandom_range(3, 0) != 0) : mr_force;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic pkt_t rpkt(input int n);
        pkt_t q;
        for (int b = 0; b < n; b++) q.push_back(W'($urandom));
        return q;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // drives one packet on source i; called and returns just after a rising edge
    task automatic send(input int i, input pkt_t d, input int lo, input int hi);
        bit acc;
        int t;
        foreach (d[b]) exp_q[i].push_back({b == d.size() - 1, d[b]});
        foreach (d[b]) begin
            sv[i] = 1'b0;
            sl[i] = 1'b0;
            repeat ($urandom_range(hi, lo)) begin
                cyc(1);
                if (rst) return;
            end
            sv[i] = 1'b1;
            sd[i] = d[b];
            sl[i] = (b == d.size() - 1);
            t = 0;
            do begin
                @(negedge clk);
                acc = s_ready[i];
                cyc(1);
                t++;
            end while (!acc && !rst && t < 300);
            if (rst || !acc) begin
                sv[i] = 1'b0;
                sl[i] = 1'b0;
                if (!rst) begin
                    checks++;
                    errors++;
                    $display("FAIL drv_bound src %0d waited %0d cycles without s_ready", i, t);
                end
                return;
            end
        end
        sv[i] = 1'b0;
        sl[i] = 1'b0;
    endtask

    task automatic wait_cond_hs(input int i);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(s_valid[i] && s_ready[i]) && t < 200);
        if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_hs src %0d no handshake after %0d cycles", i, t);
        end
    endtask

    // reference model: whole-packet round robin with a dead cycle after each packet
    int           m_ptr = N - 1;
    int           m_g   = -1;
    int           m_cnt = 0;
    logic         m_to  = 1'b0;
    logic [N-1:0] prev_g = '0;
    logic [N-1:0] eg;
    logic [W:0]   e;
    int           jj;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_grant", grant, 0);
            chk("rst_s_ready", s_ready, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_last", m_last, 0);
            chk("rst_m_data", m_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_timeout_err", timeout_err, 0);
            m_ptr  = N - 1;
            m_g    = -1;
            m_cnt  = 0;
            m_to   = 1'b0;
            prev_g = '0;
            for (int i = 0; i < N; i++) exp_q[i].delete();
        end else begin
            eg = (m_g < 0) ? '0 : N'(1) << m_g;
            chk("grant", grant, eg);
            chk("busy", busy, m_g >= 0);
            chk("timeout_err", timeout_err, m_to);
            chk("s_ready", s_ready, (m_g >= 0 && m_ready) ? eg : '0);
            chk("m_valid", m_valid, (m_g >= 0) ? sv[m_g] : 1'b0);
            if (m_g >= 0 && sv[m_g]) begin
                chk("m_data_route", m_data, sd[m_g]);
                chk("m_last_route", m_last, sl[m_g]);
            end
            if (timeout_err) to_cnt++;
            if (grant != 0 && prev_g == 0) glog.push_back(grant);
            prev_g = grant;
            m_to   = 1'b0;
            if (m_g < 0) begin
                for (int k = 1; k <= N; k++) begin
                    jj = (m_ptr + k) % N;
                    if (m_g < 0 && sv[jj]) m_g = jj;
                end
                m_cnt = 0;
            end else if (sv[m_g] && m_ready) begin
                if (exp_q[m_g].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty src %0d beat %0h accepted, none expected", m_g, m_data);
                end else begin
                    e = exp_q[m_g].pop_front();
                    chk("sb_data", m_data, e[W-1:0]);
                    chk("sb_last", m_last, e[W]);
                end
                m_cnt = 0;
                if (sl[m_g]) begin
                    m_ptr = m_g;
                    m_g   = -1;
                end
            end
`ifdef AXIS_UART_ARB_TIMEOUT_EN
            else if (!sv[m_g]) begin
                if (m_cnt == TO - 1) begin
                    m_to  = 1'b1;
                    m_ptr = m_g;
                    m_g   = -1;
                end else begin
                    m_cnt++;
                end
            end
`endif
        end
    end

    task automatic chk_order(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic [N-1:0] c, input logic [N-1:0] d, input int n);
        logic [N-1:0] ord [4];
        ord = '{a, b, c, d};
        chk({name, "_count"}, glog.size(), n);
        for (int k = 0; k < n; k++) chk(name, glog[k], ord[k]);
    endtask

    initial begin
        pkt_t p;
        pkt_t p0;
        pkt_t p1;
        int   t;
        for (int i = 0; i < N; i++) begin
            sv[i] = 1'b0;
            sl[i] = 1'b0;
            sd[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        cyc(2);

        // all sources request 2-beat packets together
        glog.delete();
        fork
            begin
                send(0, rpkt(2), 0, 0);
                send(0, rpkt(2), 0, 0);
            end
            send(1, rpkt(2), 0, 0);
            send(2, rpkt(2), 0, 0);
        join
        cyc(2);
        chk_order("order_all", 3'b001, 3'b010, 3'b100, 3'b001, 4);

        // downstream stall on the last beat of a source 1 packet
        glog.delete();
        p = '{8'hA5, 8'h5A};
        fork
            send(1, p, 0, 0);
            begin
                wait_cond_hs(1);
                mr_force = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_grant", grant, 3'b010);
                    chk("stall_data", m_data, 8'h5A);
                    chk("stall_last", m_last, 1'b1);
                end
                mr_force = 1'b1;
            end
        join
        cyc(2);
        chk_order("order_stall", 3'b010, 3'b000, 3'b000, 3'b000, 1);

        // source 0 requests while source 2 owns the path
        glog.delete();
        fork
            send(2, rpkt(4), 0, 0);
            begin
                wait_cond_hs(2);
                cyc(1);
                send(0, rpkt(2), 0, 0);
            end
        join
        cyc(2);
        chk_order("order_mid", 3'b100, 3'b001, 3'b000, 3'b000, 2);

        // reset during beat 2 of a 4-beat packet from source 2
        fork
            send(2, rpkt(4), 0, 0);
            begin
                wait_cond_hs(2);
                cyc(1);
                rst = 1'b1;
                cyc(3);
                rst = 1'b0;
            end
        join
        cyc(1);
        glog.delete();
        fork
            send(1, rpkt(1), 0, 0);
            send(2, rpkt(1), 0, 0);
        join
        cyc(2);
        chk_order("order_post_rst", 3'b010, 3'b100, 3'b000, 3'b000, 2);

`ifdef AXIS_UART_ARB_TIMEOUT_EN
        // source 0 stalls mid-packet past the limit while source 1 waits
        glog.delete();
        to_cnt = 0;
        p0 = '{8'h11, 8'h22};
        p1 = '{8'h33};
        fork
            send(0, p0, 10, 10);
            begin
                cyc(15);
                send(1, p1, 0, 0);
            end
        join
        cyc(3);
        chk("timeout_pulses", to_cnt, 1);
        chk_order("order_timeout", 3'b001, 3'b010, 3'b001, 3'b000, 3);
`endif

        // randomized traffic with random downstream backpressure
        mr_rand = 1'b1;
        for (int i = 0; i < N; i++) begin
            fork
                automatic int s = i;
                begin
                    repeat (6) send(s, rpkt($urandom_range(4, 1)), 0, 3);
                    done++;
                end
            join_none
        end
        t = 0;
        while (done < N && t < 20000) begin
            cyc(1);
            t++;
        end
        if (done < N) begin
            checks++;
            errors++;
            $display("FAIL random_phase only %0d of %0d sources finished", done, N);
        end
        mr_rand = 1'b0;
        cyc(4);
        for (int i = 0; i < N; i++) chk("sb_drained", exp_q[i].size(), 0);
        chk("idle_grant", grant, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end
endmodule
